regfile: RTL and testbench
==========================

# regfile

Architectural register file with rename tags for the out-of-order RISC-V core. It sits directly downstream of the reorder buffer: it consumes the ROB's rename announcements (nick allocated to a destination register) and its in-order commit writes. It serves registered operand lookups to the dispatch stage, returning either a ready value or the ROB nick that will produce it. A flush from the ROB discards all outstanding renames.

## Interface
- No parameters. Widths are fixed: register name 5 bits, nick 5 bits (nick 0 = "no producer"), data 32 bits.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; when low, all state and outputs hold
- iCLR  in  1  misprediction flush from ROB
- iROB_nick_en  in  1  rename valid
- iROB_nick  in  5  nick allocated to the destination
- iROB_nick_regnm  in  5  destination register being renamed
- iROB_cm_en  in  1  commit write valid
- iROB_cm_regnm  in  5  committed destination register
- iROB_cm_dt  in  32  committed value
- iROB_cm_nick  in  5  nick of the committing entry
- iDP_en  in  1  operand lookup request
- iDP_rs1, iDP_rs2  in  5 each  source register names
- oDP_valid  out  1  lookup result valid
- oDP_rs1_ready, oDP_rs2_ready  out  1 each  operand value available
- oDP_rs1_dt, oDP_rs2_dt  out  32 each  operand value (0 when not ready)
- oDP_rs1_nick, oDP_rs2_nick  out  5 each  producer nick (0 when ready)

## Operation
- State: 32 x 32-bit data array, 32 x 5-bit tag array. tag == 0 means the value is architectural and ready. x0 data and tag are constant 0.
- Rename: on iROB_nick_en with regnm != 0 and nick != 0, tag[regnm] <= nick. If either is 0, the rename is ignored.
- Commit: on iROB_cm_en with regnm != 0, data[regnm] <= cm_dt. tag[regnm] <= 0 only if tag[regnm] == cm_nick. A newer rename is kept.
- Rename and commit to the same register in the same cycle: the data is written and the tag takes the new rename nick.
- Lookup, per source rs, is evaluated against the pre-edge tag and data:
  - If rs == 0: ready=1, dt=0, nick=0.
  - Else if tag[rs] == 0: ready=1, dt=data[rs].
  - Else if bypass applies (see Configuration): ready=1, dt=cm_dt, nick=0.
  - Else: ready=0, dt=0, nick=tag[rs].
- A rename in the same cycle as a lookup does not affect that lookup. Sources see the pre-rename mapping, so addi x1,x1,1 reads the old x1.
- Flush (iCLR): all tags are cleared to 0 at the edge, and the committed data is kept. Any rename in the same cycle is ignored. A commit in the same cycle still writes its data. oDP_valid <= 0 regardless of iDP_en.
- rst: data and tags are cleared to 0. All outputs are 0.

## Timing
- Lookup latency is 1 cycle. iDP_en sampled at edge N gives oDP_valid=1 with results during cycle N+1. oDP_valid is a 1-cycle pulse per request, and back-to-back requests are allowed every cycle.
- Without iDP_en, oDP_valid <= 0. The other DP outputs hold their last values.
- A rename takes effect at the edge. A lookup issued in the next cycle sees the new nick.
- A commit takes effect at the edge. A lookup issued in the next cycle sees the data as ready.
- When rdy is low, no state updates occur and outputs hold, including oDP_valid.
- Precedence at the edge: rst > iCLR > rdy gating > normal update.

## Configuration
- RF_BYPASS_EN defined: same-cycle commit forwarding is on. If iROB_cm_en && cm_regnm == rs && cm_nick == tag[rs] != 0, the lookup returns ready with iROB_cm_dt.
- RF_BYPASS_EN undefined: no forwarding. That lookup returns ready=0 with nick=tag[rs]. The dispatcher must then capture the value from the CDB.

## Test plan
- Reset, then look up rs1=5, rs2=0: the next cycle gives valid=1, ready=1/1, dt=0/0, nick=0/0.
- Rename x3 to nick 7, then in the next cycle look up rs1=3: ready=0, nick=7. Commit x3=0xDEADBEEF with nick 7, then look up: ready=1, dt=0xDEADBEEF.
- Rename x3 to 7, then rename x3 to 9, then commit x3 with nick 7 (0x11): a lookup returns ready=0, nick=9, and the data array holds 0x11.
- With x4 tagged as nick 2, commit x4=0x55 with nick 2 in the same cycle as a lookup of rs1=4. With bypass on: ready=1, dt=0x55. With bypass off: ready=0, nick=2.
- Tag x1 to 5 and x2 to 6, then pulse iCLR together with iDP_en and a rename of x7 to 8. Required: oDP_valid=0 on the following cycle, and later lookups of x1, x2 and x7 all return ready=1 with the old data.
- A rename of x0 to nick 4 plus a commit of x0=0x99: a lookup of x0 returns ready=1, dt=0.

Source files
------------

// File: rtl/regfile.sv
// Architectural register file with rename tags: registered operand lookup for dispatch.
// Define RF_BYPASS_EN to forward a same-cycle commit to a matching lookup.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        iCLR,
  input  logic        iROB_nick_en,
  input  logic [4:0]  iROB_nick,
  input  logic [4:0]  iROB_nick_regnm,
  input  logic        iROB_cm_en,
  input  logic [4:0]  iROB_cm_regnm,
  input  logic [31:0] iROB_cm_dt,
  input  logic [4:0]  iROB_cm_nick,
  input  logic        iDP_en,
  input  logic [4:0]  iDP_rs1,
  input  logic [4:0]  iDP_rs2,
  output logic        oDP_valid,
  output logic        oDP_rs1_ready,
  output logic        oDP_rs2_ready,
  output logic [31:0] oDP_rs1_dt,
  output logic [31:0] oDP_rs2_dt,
  output logic [4:0]  oDP_rs1_nick,
  output logic [4:0]  oDP_rs2_nick
);
  localparam int DATA_W = 32;
  localparam int NICK_W = 5;
  localparam int NREG   = 32;

  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] dt;
    logic [NICK_W-1:0] nick;
  } look_t;

  logic [DATA_W-1:0] data_q [NREG];
  logic [NICK_W-1:0] tag_q  [NREG];

  logic              vld_p1;
  logic              rs1_ready_p1, rs2_ready_p1;
  logic [DATA_W-1:0] rs1_dt_p1, rs2_dt_p1;
  logic [NICK_W-1:0] rs1_nick_p1, rs2_nick_p1;

  logic  byp1_p0, byp2_p0;
  look_t look1_p0, look2_p0;

  // x0 is never written outside reset, so reading it via rs==0 short-circuits anyway.
  function automatic look_t lookup(input logic [4:0] rs, input logic [NICK_W-1:0] tag,
                                   input logic [DATA_W-1:0] dt, input logic byp,
                                   input logic [DATA_W-1:0] cm_dt);
    look_t r;
    r = '0;
    if (rs == 5'd0) begin
      r.ready = 1'b1;
    end else if (tag == '0) begin
      r.ready = 1'b1;
      r.dt    = dt;
    end else if (byp) begin
      r.ready = 1'b1;
      r.dt    = cm_dt;
    end else begin
      r.nick  = tag;
    end
    return r;
  endfunction

  // Stage p0: lookup against pre-edge tag/data
  always_comb begin
    byp1_p0 = 1'b0;
    byp2_p0 = 1'b0;
`ifdef RF_BYPASS_EN
    byp1_p0 = iROB_cm_en && (iROB_cm_regnm == iDP_rs1) &&
              (iROB_cm_nick == tag_q[iDP_rs1]) && (tag_q[iDP_rs1] != '0);
    byp2_p0 = iROB_cm_en && (iROB_cm_regnm == iDP_rs2) &&
              (iROB_cm_nick == tag_q[iDP_rs2]) && (tag_q[iDP_rs2] != '0);
`endif
    look1_p0 = lookup(iDP_rs1, tag_q[iDP_rs1], data_q[iDP_rs1], byp1_p0, iROB_cm_dt);
    look2_p0 = lookup(iDP_rs2, tag_q[iDP_rs2], data_q[iDP_rs2], byp2_p0, iROB_cm_dt);
  end

  // Stage p1: state update and registered lookup results
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      vld_p1       <= 1'b0;
      rs1_ready_p1 <= 1'b0;
      rs2_ready_p1 <= 1'b0;
      rs1_dt_p1    <= '0;
      rs2_dt_p1    <= '0;
      rs1_nick_p1  <= '0;
      rs2_nick_p1  <= '0;
    end else if (iCLR) begin
      for (int i = 0; i < NREG; i++) tag_q[i] <= '0;
      if (rdy && iROB_cm_en && iROB_cm_regnm != 5'd0)
        data_q[iROB_cm_regnm] <= iROB_cm_dt;
      vld_p1 <= 1'b0;
    end else if (rdy) begin
      if (iROB_cm_en && iROB_cm_regnm != 5'd0) begin
        data_q[iROB_cm_regnm] <= iROB_cm_dt;
        if (tag_q[iROB_cm_regnm] == iROB_cm_nick)
          tag_q[iROB_cm_regnm] <= '0;
      end
      // A same-cycle rename overrides the commit's tag release.
      if (iROB_nick_en && iROB_nick_regnm != 5'd0 && iROB_nick != '0)
        tag_q[iROB_nick_regnm] <= iROB_nick;
      vld_p1 <= iDP_en;
      if (iDP_en) begin
        rs1_ready_p1 <= look1_p0.ready;
        rs2_ready_p1 <= look2_p0.ready;
        rs1_dt_p1    <= look1_p0.dt;
        rs2_dt_p1    <= look2_p0.dt;
        rs1_nick_p1  <= look1_p0.nick;
        rs2_nick_p1  <= look2_p0.nick;
      end
    end
  end

  assign oDP_valid     = vld_p1;
  assign oDP_rs1_ready = rs1_ready_p1;
  assign oDP_rs2_ready = rs2_ready_p1;
  assign oDP_rs1_dt    = rs1_dt_p1;
  assign oDP_rs2_dt    = rs2_dt_p1;
  assign oDP_rs1_nick  = rs1_nick_p1;
  assign oDP_rs2_nick  = rs2_nick_p1;
endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed vector table followed by randomized traffic against a reference model.
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst, rdy, iCLR;
  logic        iROB_nick_en;
  logic [4:0]  iROB_nick, iROB_nick_regnm;
  logic        iROB_cm_en;
  logic [4:0]  iROB_cm_regnm, iROB_cm_nick;
  logic [31:0] iROB_cm_dt;
  logic        iDP_en;
  logic [4:0]  iDP_rs1, iDP_rs2;
  logic        oDP_valid, oDP_rs1_ready, oDP_rs2_ready;
  logic [31:0] oDP_rs1_dt, oDP_rs2_dt;
  logic [4:0]  oDP_rs1_nick, oDP_rs2_nick;

  regfile dut (
    .clk(clk), .rst(rst), .rdy(rdy), .iCLR(iCLR),
    .iROB_nick_en(iROB_nick_en), .iROB_nick(iROB_nick), .iROB_nick_regnm(iROB_nick_regnm),
    .iROB_cm_en(iROB_cm_en), .iROB_cm_regnm(iROB_cm_regnm), .iROB_cm_dt(iROB_cm_dt),
    .iROB_cm_nick(iROB_cm_nick),
    .iDP_en(iDP_en), .iDP_rs1(iDP_rs1), .iDP_rs2(iDP_rs2),
    .oDP_valid(oDP_valid), .oDP_rs1_ready(oDP_rs1_ready), .oDP_rs2_ready(oDP_rs2_ready),
    .oDP_rs1_dt(oDP_rs1_dt), .oDP_rs2_dt(oDP_rs2_dt),
    .oDP_rs1_nick(oDP_rs1_nick), .oDP_rs2_nick(oDP_rs2_nick)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rst, clr, rdy, nen;
    bit [4:0]  nreg, nick;
    bit        cen;
    bit [4:0]  creg, cnick;
    bit [31:0] cdt;
    bit        den;
    bit [4:0]  rs1, rs2;
    bit        chk;
    bit [76:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural values and pending producer per register
  bit [31:0] m_data [32];
  bit [4:0]  m_tag  [32];
  bit [76:0] m_out;

  function automatic bit [76:0] pk(bit v, bit r1, bit r2, bit [31:0] d1, bit [31:0] d2,
                                   bit [4:0] n1, bit [4:0] n2);
    return {v, r1, r2, d1, d2, n1, n2};
  endfunction

  function automatic bit [37:0] mlook(bit [4:0] rs);
    bit byp;
    byp = 1'b0;
`ifdef RF_BYPASS_EN
    byp = iROB_cm_en && iROB_cm_regnm == rs && iROB_cm_nick == m_tag[rs];
`endif
    if (rs == 0)             return {1'b1, 32'd0, 5'd0};
    if (m_tag[rs] == 0)      return {1'b1, m_data[rs], 5'd0};
    if (byp)                 return {1'b1, iROB_cm_dt, 5'd0};
    return {1'b0, 32'd0, m_tag[rs]};
  endfunction

  task automatic model_step();
    bit [37:0] a, b;
    if (rst) begin
      foreach (m_data[i]) begin m_data[i] = 0; m_tag[i] = 0; end
      m_out = '0;
    end else if (iCLR) begin
      foreach (m_tag[i]) m_tag[i] = 0;
      if (rdy && iROB_cm_en && iROB_cm_regnm != 0) m_data[iROB_cm_regnm] = iROB_cm_dt;
      m_out[76] = 1'b0;
    end else if (rdy) begin
      a = mlook(iDP_rs1);
      b = mlook(iDP_rs2);
      if (iDP_en) m_out = pk(1'b1, a[37], b[37], a[36:5], b[36:5], a[4:0], b[4:0]);
      else        m_out[76] = 1'b0;
      if (iROB_cm_en && iROB_cm_regnm != 0) begin
        m_data[iROB_cm_regnm] = iROB_cm_dt;
        if (m_tag[iROB_cm_regnm] == iROB_cm_nick) m_tag[iROB_cm_regnm] = 0;
      end
      if (iROB_nick_en && iROB_nick_regnm != 0 && iROB_nick != 0)
        m_tag[iROB_nick_regnm] = iROB_nick;
    end
  endtask

  function automatic bit [76:0] dut_out();
    return {oDP_valid, oDP_rs1_ready, oDP_rs2_ready, oDP_rs1_dt, oDP_rs2_dt,
            oDP_rs1_nick, oDP_rs2_nick};
  endfunction

  task automatic compare(string name, bit [76:0] got, bit [76:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic add(bit r, bit c, bit y, bit ne, bit [4:0] nr, bit [4:0] nk,
                     bit ce, bit [4:0] cr, bit [4:0] cn, bit [31:0] cd,
                     bit de, bit [4:0] s1, bit [4:0] s2, bit k, bit [76:0] e);
    vec_t v;
    v.rst = r; v.clr = c; v.rdy = y; v.nen = ne; v.nreg = nr; v.nick = nk;
    v.cen = ce; v.creg = cr; v.cnick = cn; v.cdt = cd;
    v.den = de; v.rs1 = s1; v.rs2 = s2; v.chk = k; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic clock_and_settle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [76:0] hold;
    rst = 1; rdy = 1; iCLR = 0; iROB_nick_en = 0; iROB_nick = 0; iROB_nick_regnm = 0;
    iROB_cm_en = 0; iROB_cm_regnm = 0; iROB_cm_dt = 0; iROB_cm_nick = 0;
    iDP_en = 0; iDP_rs1 = 0; iDP_rs2 = 0;

    //   rst clr rdy  nen reg nick  cen reg nick data          den rs1 rs2 chk expected
    add(1, 0, 1, 0, 0, 0,  0, 0, 0, 0,              0, 0, 0, 1, pk(0,0,0,0,0,0,0));
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 5, 0, 1, pk(1,1,1,0,0,0,0));
    add(0, 0, 1, 1, 3, 7,  0, 0, 0, 0,              0, 0, 0, 1, pk(0,1,1,0,0,0,0));
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 3, 3, 1, pk(1,0,0,0,0,7,7));
    add(0, 0, 1, 0, 0, 0,  1, 3, 7, 32'hDEADBEEF,   0, 0, 0, 1, pk(0,0,0,0,0,7,7));
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 3, 0, 1, pk(1,1,1,32'hDEADBEEF,0,0,0));
    hold = pk(0,1,1,32'hDEADBEEF,0,0,0);
    add(0, 0, 1, 1, 3, 7,  0, 0, 0, 0,              0, 0, 0, 1, hold);
    add(0, 0, 1, 1, 3, 9,  0, 0, 0, 0,              0, 0, 0, 1, hold);
    add(0, 0, 1, 0, 0, 0,  1, 3, 7, 32'h11,         0, 0, 0, 1, hold);
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 3, 0, 1, pk(1,0,1,0,0,9,0));
    add(0, 1, 1, 0, 0, 0,  0, 0, 0, 0,              0, 0, 0, 1, pk(0,0,1,0,0,9,0));
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 3, 0, 1, pk(1,1,1,32'h11,0,0,0));
    add(0, 0, 1, 1, 4, 2,  0, 0, 0, 0,              0, 0, 0, 1, pk(0,1,1,32'h11,0,0,0));
`ifdef RF_BYPASS_EN
    add(0, 0, 1, 0, 0, 0,  1, 4, 2, 32'h55,         1, 4, 3, 1, pk(1,1,1,32'h55,32'h11,0,0));
`else
    add(0, 0, 1, 0, 0, 0,  1, 4, 2, 32'h55,         1, 4, 3, 1, pk(1,0,1,0,32'h11,2,0));
`endif
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 4, 0, 1, pk(1,1,1,32'h55,0,0,0));
    hold = pk(0,1,1,32'h55,0,0,0);
    add(0, 0, 1, 0, 0, 0,  1, 1, 0, 32'hA1,         0, 0, 0, 1, hold);
    add(0, 0, 1, 0, 0, 0,  1, 2, 0, 32'hB2,         0, 0, 0, 1, hold);
    add(0, 0, 1, 0, 0, 0,  1, 7, 0, 32'hC7,         0, 0, 0, 1, hold);
    add(0, 0, 1, 1, 1, 5,  0, 0, 0, 0,              0, 0, 0, 1, hold);
    add(0, 0, 1, 1, 2, 6,  0, 0, 0, 0,              0, 0, 0, 1, hold);
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 1, 2, 1, pk(1,0,0,0,0,5,6));
    add(0, 1, 1, 1, 7, 8,  0, 0, 0, 0,              1, 1, 2, 1, pk(0,0,0,0,0,5,6));
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 1, 2, 1, pk(1,1,1,32'hA1,32'hB2,0,0));
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 7, 0, 1, pk(1,1,1,32'hC7,0,0,0));
    add(0, 0, 1, 1, 0, 4,  1, 0, 0, 32'h99,         1, 0, 0, 1, pk(1,1,1,0,0,0,0));
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 0, 7, 1, pk(1,1,1,0,32'hC7,0,0));
    add(0, 0, 0, 1, 7, 3,  0, 0, 0, 0,              1, 7, 0, 1, pk(1,1,1,0,32'hC7,0,0));
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 7, 0, 1, pk(1,1,1,32'hC7,0,0,0));
    hold = pk(0,1,1,32'hC7,0,0,0);
    add(0, 0, 1, 1, 5, 10, 0, 0, 0, 0,              0, 0, 0, 1, hold);
    add(0, 0, 1, 1, 5, 11, 1, 5, 10, 32'h5A,        0, 0, 0, 1, hold);
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 5, 0, 1, pk(1,0,1,0,0,11,0));
    add(0, 0, 1, 0, 0, 0,  1, 5, 11, 32'h5B,        0, 0, 0, 1, pk(0,0,1,0,0,11,0));
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 5, 0, 1, pk(1,1,1,32'h5B,0,0,0));
    add(0, 0, 1, 1, 6, 12, 0, 0, 0, 0,              1, 6, 6, 1, pk(1,1,1,0,0,0,0));
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 6, 0, 1, pk(1,0,1,0,0,12,0));
    add(0, 0, 1, 1, 6, 0,  0, 0, 0, 0,              0, 0, 0, 1, pk(0,0,1,0,0,12,0));
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,              1, 6, 0, 1, pk(1,0,1,0,0,12,0));
    add(1, 0, 1, 0, 0, 0,  0, 0, 0, 0,              0, 0, 0, 1, pk(0,0,0,0,0,0,0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; iCLR = vecs[i].clr; rdy = vecs[i].rdy;
      iROB_nick_en = vecs[i].nen; iROB_nick_regnm = vecs[i].nreg; iROB_nick = vecs[i].nick;
      iROB_cm_en = vecs[i].cen; iROB_cm_regnm = vecs[i].creg; iROB_cm_nick = vecs[i].cnick;
      iROB_cm_dt = vecs[i].cdt;
      iDP_en = vecs[i].den; iDP_rs1 = vecs[i].rs1; iDP_rs2 = vecs[i].rs2;
      clock_and_settle();
      if (vecs[i].chk) compare($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end

    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 299) == 0);
      iCLR = ($urandom_range(0, 24) == 0);
      rdy  = ($urandom_range(0, 9) != 0);
      iROB_nick_en    = $urandom_range(0, 1);
      iROB_nick_regnm = $urandom_range(0, 7);
      iROB_nick       = $urandom_range(0, 15);
      iROB_cm_en      = $urandom_range(0, 1);
      iROB_cm_regnm   = $urandom_range(0, 7);
      iROB_cm_dt      = $urandom;
      iROB_cm_nick    = ($urandom_range(0, 2) != 0) ? m_tag[iROB_cm_regnm] : 5'($urandom_range(0, 15));
      iDP_en  = ($urandom_range(0, 3) != 0);
      iDP_rs1 = ($urandom_range(0, 1) != 0) ? iROB_cm_regnm : 5'($urandom_range(0, 7));
      iDP_rs2 = $urandom_range(0, 31);
      if (iCLR && iROB_cm_en) rdy = 1'b1;
      clock_and_settle();
      compare($sformatf("rand%0d", n), dut_out(), m_out);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
